// File: rtl/button_debounce_strobe_if.sv
// Button debouncer signal bundle: raw button in, debounced level and edge strobes out.
interface button_debounce_strobe_if;
  logic btn_i;
  logic level_o;
  logic press_o;
  logic release_o;

  modport master (
    output btn_i,
    input  level_o,
    input  press_o,
    input  release_o
  );

  modport slave (
    input  btn_i,
    output level_o,
    output press_o,
    output release_o
  );
endinterface

// File: rtl/button_debounce_strobe.sv
// Push-button debouncer: two-flop synchronizer, four-state qualification FSM,
// registered debounced level with one-cycle press/release strobes.
module button_debounce_strobe #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  button_debounce_strobe_if.slave bus
);

  localparam logic [1:0] ST_LOW  = 2'd0;
  localparam logic [1:0] ST_RISE = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_FALL = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  // A single stable sample is enough: skip the qualifying states entirely.
  localparam bit DIRECT = (DEBOUNCE_CYCLES == 1);

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 level_q, level_d;
  logic                 press_q, press_d;
  logic                 release_q, release_d;

  always_comb begin
    sync1_d = bus.btn_i;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = '0;

    case (state_q)
      ST_LOW: begin
        if (sync2_q) begin
          if (DIRECT) begin
            state_d = ST_HIGH;
          end else begin
            state_d = ST_RISE;
            cnt_d   = CNT_ONE;
          end
        end
      end
      ST_RISE: begin
        if (!sync2_q) begin
          state_d = ST_LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!sync2_q) begin
          if (DIRECT) begin
            state_d = ST_LOW;
          end else begin
            state_d = ST_FALL;
            cnt_d   = CNT_ONE;
          end
        end
      end
      ST_FALL: begin
        if (sync2_q) begin
          state_d = ST_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOW;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = ST_LOW;
    endcase

    // Strobes are derived from the next level so they line up with level_o's change.
    level_d   = (state_d == ST_HIGH) || (state_d == ST_FALL);
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= ST_LOW;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign bus.level_o   = level_q;
  assign bus.press_o   = press_q;
  assign bus.release_o = release_q;

endmodule

// File: tb/tb_button_debounce_strobe.sv
// Bench for button_debounce_strobe: two instances (4-sample and 1-sample qualification)
// driven by the same button, checked every cycle against a run-length reference model.
module tb_button_debounce_strobe;

  logic clk;
  logic rst_n;
  logic btn;

  button_debounce_strobe_if bif4 ();
  button_debounce_strobe_if bif1 ();

  assign bif4.btn_i = btn;
  assign bif1.btn_i = btn;

  button_debounce_strobe #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(3)) dut4 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bif4)
  );

  button_debounce_strobe #(.DEBOUNCE_CYCLES(1), .CNT_WIDTH(3)) dut1 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bif1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int passed = 0;
  int total  = 0;

  // Reference model: button seen through two sample delays; the level flips once
  // D consecutive samples disagree with it.
  int   m_d [2] = '{4, 1};
  logic m_s1, m_s2;
  logic m_lvl [2];
  int   m_run [2];
  logic m_press [2];
  logic m_rel [2];

  int edge_no;
  int p4, r4, p1, r1;
  int lat4, lat1;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_s1 = 1'b0;
    m_s2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_lvl[i]   = 1'b0;
      m_run[i]   = 0;
      m_press[i] = 1'b0;
      m_rel[i]   = 1'b0;
    end
  endtask

  task automatic clear_stats();
    edge_no = 0;
    p4 = 0; r4 = 0; p1 = 0; r1 = 0;
    lat4 = 0; lat1 = 0;
  endtask

  task automatic check_outputs();
    chk("level4",   bif4.level_o,   m_lvl[0]);
    chk("press4",   bif4.press_o,   m_press[0]);
    chk("release4", bif4.release_o, m_rel[0]);
    chk("level1",   bif1.level_o,   m_lvl[1]);
    chk("press1",   bif1.press_o,   m_press[1]);
    chk("release1", bif1.release_o, m_rel[1]);
    chk("coincident4", bif4.press_o & bif4.release_o, 1'b0);
    chk("coincident1", bif1.press_o & bif1.release_o, 1'b0);
  endtask

  task automatic step(input logic b);
    logic s;
    btn = b;
    @(posedge clk);
    edge_no++;
    if (rst_n) begin
      s    = m_s2;
      m_s2 = m_s1;
      m_s1 = b;
      for (int i = 0; i < 2; i++) begin
        m_press[i] = 1'b0;
        m_rel[i]   = 1'b0;
        if (s != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == m_d[i]) begin
            m_lvl[i]   = s;
            m_run[i]   = 0;
            m_press[i] = s;
            m_rel[i]   = ~s;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end else begin
      model_reset();
    end
    #1;
    check_outputs();
    if (bif4.press_o)   p4++;
    if (bif4.release_o) r4++;
    if (bif1.press_o)   p1++;
    if (bif1.release_o) r1++;
    if (bif4.press_o && lat4 == 0) lat4 = edge_no;
    if (bif1.press_o && lat1 == 0) lat1 = edge_no;
  endtask

  initial begin
    logic rb;
    int   len;

    btn   = 1'b0;
    rst_n = 1'b0;
    model_reset();
    clear_stats();
    #1;
    chk("reset_level4", bif4.level_o, 1'b0);
    chk("reset_press4", bif4.press_o, 1'b0);
    repeat (3) step(1'b0);
    rst_n = 1'b1;
    repeat (3) step(1'b0);

    // Clean press held 20 cycles
    clear_stats();
    repeat (20) step(1'b1);
    chk_int("clean_latency4", lat4, 6);
    chk_int("clean_latency1", lat1, 3);
    chk_int("clean_presses4", p4, 1);
    chk_int("clean_releases4", r4, 0);
    chk_int("clean_presses1", p1, 1);
    repeat (12) step(1'b0);

    // Bounce 1,0,1,0... for 8 cycles, then stable high
    clear_stats();
    for (int i = 0; i < 8; i++) step(((i % 2) == 0) ? 1'b1 : 1'b0);
    chk_int("bounce_no_strobe4", p4 + r4, 0);
    clear_stats();
    repeat (15) step(1'b1);
    chk_int("bounce_latency4", lat4, 6);
    chk_int("bounce_presses4", p4, 1);
    chk_int("bounce_releases4", r4, 0);

    // 3-cycle low glitch while high, then 3-cycle high glitch while low
    clear_stats();
    repeat (3) step(1'b0);
    repeat (12) step(1'b1);
    chk_int("low_glitch_releases4", r4, 0);
    chk("low_glitch_level4", bif4.level_o, 1'b1);
    repeat (12) step(1'b0);
    clear_stats();
    repeat (3) step(1'b1);
    repeat (12) step(1'b0);
    chk_int("high_glitch_presses4", p4, 0);
    chk("high_glitch_level4", bif4.level_o, 1'b0);
    chk_int("high_glitch_presses1", p1, 1);

    // Press 10 cycles then release 10 cycles
    clear_stats();
    repeat (10) step(1'b1);
    repeat (10) step(1'b0);
    chk_int("pr_presses4", p4, 1);
    chk_int("pr_releases4", r4, 1);
    chk_int("pr_presses1", p1, 1);
    chk_int("pr_releases1", r1, 1);

    // Asynchronous reset while the 4-sample instance is qualifying (counter at 2)
    clear_stats();
    repeat (4) step(1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_level1", bif1.level_o, 1'b0);
    chk("async_rst_level4", bif4.level_o, 1'b0);
    chk("async_rst_press4", bif4.press_o, 1'b0);
    chk("async_rst_release1", bif1.release_o, 1'b0);
    model_reset();
    repeat (3) step(1'b1);
    rst_n = 1'b1;
    clear_stats();
    repeat (12) step(1'b1);
    chk_int("post_rst_latency4", lat4, 6);
    chk_int("post_rst_presses4", p4, 1);
    chk_int("post_rst_latency1", lat1, 3);
    chk_int("post_rst_releases1", r1, 0);

    // Randomized runs of random length
    rb = 1'b1;
    repeat (60) begin
      rb  = ($urandom_range(0, 3) == 0) ? rb : ~rb;
      len = $urandom_range(1, 7);
      repeat (len) step(rb);
    end
    repeat (10) step(1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/button_debounce_strobe.md
BUTTON_DEBOUNCE_STROBE -- requirements
Module: button_debounce_strobe

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000: consecutive stable synchronized samples required to accept a level change; legal range 1 to 2^CNT_WIDTH-1.
REQ-002 Parameter CNT_WIDTH, default 16: width of the debounce counter.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 btn_i  input  1  raw, asynchronous, bouncing push-button level; high = pressed.
REQ-006 level_o  output  1  debounced button level, registered.
REQ-007 press_o  output  1  one-cycle strobe on accepted low-to-high change; drives en_i of a downstream enable flip-flop stage.
REQ-008 release_o  output  1  one-cycle strobe on accepted high-to-low change.

Function
REQ-009 btn_i SHALL pass through a two-flop synchronizer; only the second flop output (sync) feeds the FSM and counter.
REQ-010 FSM SHALL have exactly four states: LOW, RISE, HIGH, FALL; level_o SHALL be 0 in LOW and RISE, 1 in HIGH and FALL.
REQ-011 LOW: sync=1 -> RISE with counter loaded to 1; else stay, counter 0.
REQ-012 RISE: sync=0 -> LOW, counter 0 (bounce rejected); sync=1 and counter=DEBOUNCE_CYCLES-1 -> HIGH, counter 0; else counter+1.
REQ-013 HIGH: sync=0 -> FALL with counter loaded to 1; else stay, counter 0.
REQ-014 FALL: sync=1 -> HIGH, counter 0; sync=0 and counter=DEBOUNCE_CYCLES-1 -> LOW, counter 0; else counter+1.
REQ-015 DEBOUNCE_CYCLES=1: LOW/HIGH SHALL transition directly to HIGH/LOW on the first differing sample, skipping RISE/FALL.
REQ-016 Counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-017 press_o SHALL be registered and high for exactly the first cycle in which level_o is 1 after being 0; release_o likewise for 1-to-0.
REQ-018 press_o and release_o SHALL never be high in the same cycle; no strobe without a level_o change.
REQ-019 Latency: btn_i rising cleanly before edge N yields level_o=1 and press_o=1 after edge N+1+DEBOUNCE_CYCLES (2 synchronizer edges + DEBOUNCE_CYCLES counting edges, first overlapping).
REQ-020 Any opposite sample during RISE/FALL SHALL restart qualification from scratch; no partial credit retained.
REQ-021 A held button SHALL produce exactly one press_o, regardless of hold duration.

Reset
REQ-022 rst_ni low SHALL immediately, without clock, force: state LOW, counter 0, synchronizer flops 0, level_o 0, press_o 0, release_o 0.
REQ-023 Reset asserted mid-qualification (RISE/FALL) or while HIGH SHALL discard progress; no strobe SHALL be emitted during or on exit from reset.
REQ-024 After rst_ni rises with btn_i held high, a full qualification SHALL follow and exactly one press_o SHALL result.

Verification (bench uses DEBOUNCE_CYCLES=4, CNT_WIDTH=3)
REQ-025 Clean press: btn_i 0->1 held 20 cycles -> level_o rises and press_o pulses exactly 1 cycle, 6 edges after first sampling edge; no release_o.
REQ-026 Bounce: btn_i toggles 1,0,1,0 each cycle for 8 cycles, then stable 1 -> no strobe during bouncing; single press_o 6 edges after stable 1 begins.
REQ-027 Glitch: btn_i high for 3 cycles only while level_o=0 -> level_o stays 0, no press_o; same 3-cycle low glitch while level_o=1 -> no release_o.
REQ-028 Press/release: press held 10 cycles, release held 10 cycles -> exactly one press_o then one release_o, each 1 cycle, never coincident.
REQ-029 Reset mid-operation: rst_ni pulled low asynchronously between edges while in RISE with counter=2 -> all outputs 0 immediately; btn_i still high after release -> one press_o 6 edges later.
REQ-030 Parameter edge: DEBOUNCE_CYCLES=1 rerun of REQ-025 -> press_o 3 edges after btn_i rise; a 1-cycle glitch IS accepted as press.
